// File: rtl/poly_add_mod_q.sv
// Lane-wise modular add/subtract of two polynomials held in a single-port-style RAM.
// Each 96-bit RAM word carries 8 coefficients of 12 bits; the result is written back
// word by word to a third region.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin an operation (honoured only when idle)
//   sub             - 0: C = A + B mod Q, 1: C = A - B mod Q (latched at start)
//   a_base, b_base  - word address of operand A / B word 0 (latched at start)
//   w_base          - word address of result word 0 (latched at start)
//   ren, raddr      - RAM read request; rdata returns one cycle later
//   rdata           - RAM read data
//   enw, waddr,dout - RAM write port
//   busy            - operation in flight (RA/RB/WR)
//   done            - one-cycle pulse after the last word is written
module poly_add_mod_q #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned NWORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [7:0]  a_base,
    input  logic [7:0]  b_base,
    input  logic [7:0]  w_base,
    output logic        ren,
    output logic [7:0]  raddr,
    input  logic [95:0] rdata,
    output logic        enw,
    output logic [7:0]  waddr,
    output logic [95:0] dout,
    output logic        busy,
    output logic        done
);

    localparam int unsigned LANES = 8;
    localparam int unsigned LW    = 12;
    localparam int unsigned WW    = LANES * LW;
    localparam int unsigned AW    = 8;
    localparam int unsigned IW    = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RA   = 3'd1,
        S_RB   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [WW-1:0]   a_reg_q, a_reg_d;
    logic            sub_q, sub_d;
    logic [AW-1:0]   a_base_q, a_base_d;
    logic [AW-1:0]   b_base_q, b_base_d;
    logic [AW-1:0]   w_base_q, w_base_d;

    logic [WW-1:0]   lane_res;
    logic            last_word;

    // One coefficient lane; operands are assumed reduced, so one conditional correction suffices.
    function automatic logic [LW-1:0] lane_op(input logic op_sub,
                                              input logic [LW-1:0] x,
                                              input logic [LW-1:0] y);
        logic [LW:0] s;
        if (!op_sub) begin
            s = (LW+1)'(x) + (LW+1)'(y);
            if (s >= (LW+1)'(Q)) begin
                s = s - (LW+1)'(Q);
            end
        end else begin
            if (x >= y) begin
                s = (LW+1)'(x) - (LW+1)'(y);
            end else begin
                s = (LW+1)'(x) + (LW+1)'(Q) - (LW+1)'(y);
            end
        end
        return LW'(s);
    endfunction

    // A word held in a_reg_q, B word arriving on rdata during WR.
    always_comb begin
        lane_res = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_res[LW*j +: LW] = lane_op(sub_q, a_reg_q[LW*j +: LW], rdata[LW*j +: LW]);
        end
    end

    assign last_word = (i_q == IW'(NWORDS - 1));

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            a_reg_q  <= '0;
            sub_q    <= 1'b0;
            a_base_q <= '0;
            b_base_q <= '0;
            w_base_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            a_reg_q  <= a_reg_d;
            sub_q    <= sub_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            w_base_q <= w_base_d;
        end
    end

    // Next state and RAM-side outputs; the WR state also issues the next A read.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        a_reg_d  = a_reg_q;
        sub_d    = sub_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        w_base_d = w_base_q;
        ren      = 1'b0;
        raddr    = '0;
        enw      = 1'b0;
        waddr    = '0;
        dout     = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sub_d    = sub;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    w_base_d = w_base;
                    i_d      = '0;
                    state_d  = S_RA;
                end
            end
            S_RA: begin
                busy    = 1'b1;
                ren     = 1'b1;
                raddr   = a_base_q + AW'(i_q);
                state_d = S_RB;
            end
            S_RB: begin
                busy    = 1'b1;
                ren     = 1'b1;
                raddr   = b_base_q + AW'(i_q);
                a_reg_d = rdata;
                state_d = S_WR;
            end
            S_WR: begin
                busy  = 1'b1;
                enw   = 1'b1;
                waddr = w_base_q + AW'(i_q);
                dout  = lane_res;
                if (!last_word) begin
                    ren     = 1'b1;
                    raddr   = a_base_q + AW'(i_q) + AW'(1);
                    i_d     = i_q + IW'(1);
                    state_d = S_RB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/poly_add_mod_q.md
POLY_ADD_MOD_Q -- requirements
Module: poly_add_mod_q

Interface
REQ-001 Parameter Q, default 3329, Kyber modulus applied to every coefficient lane.
REQ-002 Parameter NWORDS, default 32, 96-bit RAM words per polynomial (8 coefficients x 12 bits each).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = C=A+B mod Q, 1 = C=A-B mod Q; latched at start.
REQ-007 a_base  input  8  RAM word address of operand A word 0; latched at start.
REQ-008 b_base  input  8  RAM word address of operand B word 0; latched at start.
REQ-009 w_base  input  8  RAM word address of result word 0; latched at start.
REQ-010 ren  output  1  RAM read enable.
REQ-011 raddr  output  8  RAM read address.
REQ-012 rdata  input  96  RAM read data, valid exactly one cycle after the ren cycle that requested it.
REQ-013 enw  output  1  RAM write enable, same-cycle write.
REQ-014 waddr  output  8  RAM write address.
REQ-015 dout  output  96  RAM write data, 8 lanes of 12 bits, lane j = bits [12j+11:12j].
REQ-016 busy  output  1  high in states RA, RB and WR.
REQ-017 done  output  1  one-cycle pulse when the last word has been written.

Function
REQ-018 States: IDLE, RA, RB, WR, DONE; word counter i is 5 bits (0..NWORDS-1).
REQ-019 IDLE: start=1 latches sub/a_base/b_base/w_base, clears i, and moves to RA; start=0 stays in IDLE.
REQ-020 RA: ren=1, raddr=a_base+i; next state RB.
REQ-021 RB: ren=1, raddr=b_base+i; the A word on rdata is captured into a 96-bit register; next state WR.
REQ-022 WR: enw=1, waddr=w_base+i, dout=lane-wise op(A register, rdata); if i<NWORDS-1, also ren=1, raddr=a_base+i+1, then i increments and the next state is RB; else next state DONE.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-024 Timing: start sampled at cycle 0 -> word i written at cycle 3+2i; last write at cycle 65; done at cycle 66; ready for a new start at cycle 67.
REQ-025 Outputs outside their active states are 0: ren, raddr, enw, waddr, dout, done.
REQ-026 Add: s=a+b in 13 bits; result = s-Q if s>=Q, else s.
REQ-027 Sub: result = a-b if a>=b, else a+Q-b; computed in 13 bits and truncated to 12.
REQ-028 Operands are guaranteed in [0,Q-1]; the result is always in [0,Q-1]; lane j of dout depends only on lane j of A and lane j of B.
REQ-029 Address arithmetic is 8-bit and wraps modulo 256 (for example, base 8'hF0 plus i=31 gives 8'h0F).
REQ-030 In-place operation (w_base==a_base or w_base==b_base) gives the correct result; any other overlap between the result range and an operand range is unsupported.
REQ-031 start while not in IDLE is ignored; input changes after start have no effect on the operation in flight.

Reset
REQ-032 rst=1 at a rising edge forces IDLE, i=0 and clears the A register and latched bases, taking priority over all other inputs including start.
REQ-033 All outputs are 0 in the cycle after reset, including when reset is asserted mid-operation; no further write follows reset.

Verification
REQ-034 Add: A all lanes 3000, B all lanes 500 -> every result lane 171; done at cycle 66; exactly 32 writes.
REQ-035 Sub: A lane 0 = 5, B lane 0 = 10 -> lane 0 = 3324; A=B=3328 -> 0; A=0, B=0 -> 0.
REQ-036 In-place: w_base=a_base=0, b_base=32, sub=0 -> words 0..31 hold A+B mod Q; B words unchanged.
REQ-037 Wrap: a_base=8'hF0 -> raddr sequence F0,b_base,F1,...,0F; the write addresses wrap the same way.
REQ-038 Reset at cycle 20 -> enw=0 from cycle 21 on, no done pulse, busy=0; a new start afterwards completes normally.
REQ-039 start pulsed at cycles 10 and 40 during an operation -> both ignored; a single done pulse at cycle 66.
